// File: rtl/disp_capture.sv
// disp_capture: scan-clock divider with periodic/manual snapshot of eight
// live CPU registers into a double-buffered shadow bank for a display stage.
module disp_capture #(
  parameter int unsigned SCAN_HALF   = 25000,
  parameter int unsigned AUTO_PERIOD = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] reg_0,
  input  logic [15:0] reg_1,
  input  logic [15:0] reg_2,
  input  logic [15:0] reg_3,
  input  logic [15:0] reg_4,
  input  logic [15:0] reg_5,
  input  logic [15:0] reg_6,
  input  logic [15:0] reg_7,
  input  logic        cap_req,
  input  logic        freeze,
  output logic [15:0] shadow_0,
  output logic [15:0] shadow_1,
  output logic [15:0] shadow_2,
  output logic [15:0] shadow_3,
  output logic [15:0] shadow_4,
  output logic [15:0] shadow_5,
  output logic [15:0] shadow_6,
  output logic [15:0] shadow_7,
  output logic        sl_clk,
  output logic        cap_busy,
  output logic        cap_done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    COMMIT  = 2'd2
  } state_e;

  localparam logic [15:0] DIV_LAST  = 16'(SCAN_HALF - 1);
  localparam bit          AUTO_EN   = (AUTO_PERIOD != 0);
  localparam logic [7:0]  AUTO_LAST = AUTO_EN ? 8'(AUTO_PERIOD - 1) : 8'd0;

  logic [15:0] regs [8];

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic        pend_q, pend_d;
  logic [15:0] div_q, div_d;
  logic        sl_clk_q, sl_clk_d;
  logic [7:0]  auto_cnt_q, auto_cnt_d;
  logic        auto_trig_q, auto_trig_d;
  logic        cap_done_q, cap_done_d;
  logic [15:0] staging_q [8];
  logic [15:0] staging_d [8];
  logic [15:0] shadow_q  [8];
  logic [15:0] shadow_d  [8];
  logic        auto_go;

  assign regs[0] = reg_0;
  assign regs[1] = reg_1;
  assign regs[2] = reg_2;
  assign regs[3] = reg_3;
  assign regs[4] = reg_4;
  assign regs[5] = reg_5;
  assign regs[6] = reg_6;
  assign regs[7] = reg_7;

  // A trigger already registered is still ignored if freeze rises meanwhile.
  assign auto_go = auto_trig_q && !freeze;

  // Scan divider, sl_clk toggle and auto-capture rising-edge counter.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    div_d       = div_q + 16'd1;
    sl_clk_d    = sl_clk_q;
    auto_cnt_d  = auto_cnt_q;
    auto_trig_d = 1'b0;
    if (div_q == DIV_LAST) begin
      div_d    = 16'd0;
      sl_clk_d = ~sl_clk_q;
      if (!sl_clk_q && AUTO_EN && !freeze) begin
        if (auto_cnt_q == AUTO_LAST) begin
          auto_cnt_d  = 8'd0;
          auto_trig_d = 1'b1;
        end else begin
          auto_cnt_d = auto_cnt_q + 8'd1;
        end
      end
    end
    if (freeze || !AUTO_EN) auto_cnt_d = 8'd0;
  end

  // Capture FSM: sample eight registers into staging, then commit atomically.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pend_d     = pend_q;
    staging_d  = staging_q;
    shadow_d   = shadow_q;
    cap_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cap_req || auto_go || pend_q) begin
          state_d = CAPTURE;
          idx_d   = 3'd0;
          pend_d  = 1'b0;
        end
      end
      CAPTURE: begin
        staging_d[idx_q] = regs[idx_q];
        idx_d            = idx_q + 3'd1;
        if (cap_req) pend_d = 1'b1;
        if (idx_q == 3'd7) state_d = COMMIT;
      end
      COMMIT: begin
        shadow_d   = staging_q;
        cap_done_d = 1'b1;
        state_d    = IDLE;
        if (cap_req) pend_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= 3'd0;
      pend_q      <= 1'b0;
      div_q       <= 16'd0;
      sl_clk_q    <= 1'b0;
      auto_cnt_q  <= 8'd0;
      auto_trig_q <= 1'b0;
      cap_done_q  <= 1'b0;
      // NOTE: staging and shadow are small register banks that must read zero after reset, so they are reset like any flop (not RAM).
      staging_q   <= '{default: 16'h0000};
      shadow_q    <= '{default: 16'h0000};
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      div_q       <= div_d;
      sl_clk_q    <= sl_clk_d;
      auto_cnt_q  <= auto_cnt_d;
      auto_trig_q <= auto_trig_d;
      cap_done_q  <= cap_done_d;
      staging_q   <= staging_d;
      shadow_q    <= shadow_d;
    end
  end

  assign sl_clk   = sl_clk_q;
  assign cap_busy = (state_q != IDLE);
  assign cap_done = cap_done_q;
  assign shadow_0 = shadow_q[0];
  assign shadow_1 = shadow_q[1];
  assign shadow_2 = shadow_q[2];
  assign shadow_3 = shadow_q[3];
  assign shadow_4 = shadow_q[4];
  assign shadow_5 = shadow_q[5];
  assign shadow_6 = shadow_q[6];
  assign shadow_7 = shadow_q[7];

endmodule

// File: doc/disp_capture.md
DISP_CAPTURE -- requirements
Module: disp_capture

Interface
REQ-001 SHALL have parameter SCAN_HALF, default 25000: clk cycles per half-period of sl_clk; legal range 1..65535.
REQ-002 SHALL have parameter AUTO_PERIOD, default 100: sl_clk rising edges between automatic captures; 0 disables auto capture; legal range 0..255.
REQ-003 SHALL have one clock; reset is synchronous and active-high: clk  in  1  system clock; rst  in  1  synchronous active-high reset.
REQ-004 SHALL have reg_0 .. reg_7  in  16 each  live CPU register values.
REQ-005 SHALL have cap_req  in  1  manual capture request, sampled each clk.
REQ-006 SHALL have freeze  in  1  level; 1 suppresses auto capture.
REQ-007 SHALL have shadow_0 .. shadow_7  out  16 each  captured values for the display stage.
REQ-008 SHALL have sl_clk  out  1  divided scan clock for the display select counter.
REQ-009 SHALL have cap_busy  out  1, cap_done  out  1 (single-cycle pulse).

Function
REQ-010 SHALL run a 16-bit divider that counts 0..SCAN_HALF-1, wraps to 0 at terminal and toggles sl_clk on that same edge; sl_clk period = 2*SCAN_HALF clk.
REQ-011 SHALL count sl_clk 0->1 transitions in an 8-bit auto counter; at AUTO_PERIOD-1 on such a transition it raises an internal auto trigger for one clk and wraps to 0.
REQ-012 SHALL hold the auto counter at 0 while freeze=1 or AUTO_PERIOD=0; no auto trigger in either case.
REQ-013 SHALL use states IDLE, CAPTURE, COMMIT.
REQ-014 IDLE: on cap_req=1 or auto trigger SHALL enter CAPTURE with index 0 next cycle; both simultaneously SHALL start exactly one capture.
REQ-015 CAPTURE: each cycle SHALL write reg_<index> into staging[index] and increment index; after index 7 is written SHALL enter COMMIT (exactly 8 CAPTURE cycles).
REQ-016 COMMIT: SHALL copy all 8 staging words to shadow_0..7 in one clk edge, so shadow outputs never show a partial update; then SHALL return to IDLE.
REQ-017 Latency: cap_req high in IDLE at cycle N -> capture of reg_k at cycle N+1+k -> new shadow values and cap_done=1 at cycle N+10 only.
REQ-018 cap_busy SHALL be 1 exactly in CAPTURE and COMMIT, registered with state.
REQ-019 cap_req=1 during CAPTURE or COMMIT SHALL set a single pending flag; further requests while pending is set are discarded.
REQ-020 On return to IDLE with pending set, SHALL clear pending and enter CAPTURE on the next cycle (one IDLE cycle between captures).
REQ-021 Auto triggers arriving outside IDLE SHALL be dropped, never set pending.
REQ-022 cap_req SHALL be honoured regardless of freeze.
REQ-023 shadow outputs SHALL change only at the COMMIT edge and otherwise hold.

Reset
REQ-024 rst=1 at a clk edge SHALL force: state IDLE, index 0, pending 0, divider 0, auto counter 0, sl_clk 0, cap_busy 0, cap_done 0, staging and all shadow_* 16'h0000.
REQ-025 rst asserted mid-CAPTURE or COMMIT SHALL abort with no shadow update and no cap_done.
REQ-026 After rst deasserts, first sl_clk toggle SHALL occur SCAN_HALF cycles later.

Verification
REQ-027 SCAN_HALF=4, AUTO_PERIOD=0: after reset -> sl_clk toggles every 4 clk, period 8, no captures.
REQ-028 reg_k=16'h1000+k, cap_req pulse at N -> cap_busy N+1..N+9, cap_done only at N+10, shadow_k=16'h1000+k from N+10.
REQ-029 Change reg_0 to 16'hBEEF at N+3 during capture -> shadow_0 keeps value sampled at N+1; shadows stay 0 until N+10.
REQ-030 Two cap_req pulses during one capture -> exactly two cap_done pulses total; second capture starts one cycle after first returns to IDLE.
REQ-031 SCAN_HALF=2, AUTO_PERIOD=3, freeze=0 -> capture every 12 clk; freeze=1 -> none; cap_req under freeze -> one capture.
REQ-032 rst at N+5 of a capture -> all shadow_* 0, cap_done never pulses, sl_clk 0.
